// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the CPU's unified 1024x16 memory.
// It receives a byte stream LEN_HI, LEN_LO, N x (DATA_HI, DATA_LO), CHK and packs
// each byte pair into a 16-bit word. Words are written from address 0 upward.
// When the XOR checksum matches, the CPU is released from reset. The CPU's eop
// flag is then watched to report completion.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_data       host byte stream (valid/ready handshake)
//   in_ready               loader can accept a byte this cycle
//   restart                one-cycle pulse; in DONE or ERR, return to loading
//   mem_we/addr/wdata      memory write port, one strobe cycle per word
//   cpu_reset_n            CPU active-low reset (1 releases the CPU)
//   eop                    CPU end-of-program flag
//   done, error            completion / load rejected
//   word_count             words written in the current load
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset_n,
  input  logic              eop,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        hi_q, hi_d;
  logic              in_ready_d, mem_we_d, cpu_reset_n_d, done_d, error_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [ADDR_W:0]   word_count_d;
  logic              accept_c;
  logic [LEN_W-1:0]  n_c;
  logic              last_c;

  assign accept_c = in_valid && in_ready;
  // Full program length as it becomes known on the LEN_LO byte.
  assign n_c      = {len_q[LEN_W-1:8], in_data};
  // word_count has already advanced past every earlier word when the next DATA_LO arrives.
  assign last_c   = (LEN_W'(word_count) + LEN_W'(1)) == len_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      chk_q       <= '0;
      hi_q        <= '0;
      in_ready    <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      hi_q        <= hi_d;
      in_ready    <= in_ready_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_reset_n <= cpu_reset_n_d;
      done        <= done_d;
      error       <= error_d;
      word_count  <= word_count_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    chk_d         = chk_q;
    hi_d          = hi_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    cpu_reset_n_d = cpu_reset_n;
    done_d        = done;
    error_d       = error;
    word_count_d  = word_count;

    // Advance the write pointer at the end of each strobe cycle. The address
    // wraps naturally after word MAX_WORDS-1.
    if (mem_we) begin
      mem_addr_d   = mem_addr + ADDR_W'(1);
      word_count_d = word_count + (ADDR_W + 1)'(1);
    end

    case (state_q)
      LEN_HI: if (accept_c) begin
        len_d   = {in_data, 8'h00};
        chk_d   = chk_q ^ in_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (accept_c) begin
        len_d = n_c;
        chk_d = chk_q ^ in_data;
        if (n_c == '0 || n_c > LEN_W'(MAX_WORDS)) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          state_d = DATA_HI;
        end
      end
      DATA_HI: if (accept_c) begin
        hi_d    = in_data;
        chk_d   = chk_q ^ in_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (accept_c) begin
        mem_wdata_d = DATA_W'({hi_q, in_data});
        mem_we_d    = 1'b1;
        chk_d       = chk_q ^ in_data;
        state_d     = last_c ? CHECK : DATA_HI;
      end
      CHECK: if (accept_c) begin
        if (in_data == chk_q) begin
          state_d       = RUN;
          cpu_reset_n_d = 1'b1;
        end else begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      RUN: if (eop) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE, ERR: if (restart) begin
        state_d       = LEN_HI;
        mem_addr_d    = '0;
        word_count_d  = '0;
        chk_d         = '0;
        done_d        = 1'b0;
        error_d       = 1'b0;
        cpu_reset_n_d = 1'b0;
      end
      default: state_d = LEN_HI;
    endcase

    in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) || (state_d == DATA_HI) ||
                 (state_d == DATA_LO) || (state_d == CHECK);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. Each program word is pushed to a scoreboard when
// its low byte is accepted. A monitor pops the entry on every mem_we strobe and
// compares the address, the data and the strobe cycle.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset_n;
  logic        eop;
  logic        done;
  logic        error;
  logic [10:0] word_count;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  logic [15:0] prog[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc;
  logic [7:0]  run_chk;

  prog_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset_n(cpu_reset_n), .eop(eop), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_we", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("we_addr", 32'(mem_addr), 32'(e.addr));
        check("we_data", 32'(mem_wdata), 32'(e.data));
        check("we_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Offer one byte and wait (bounded) for it to be accepted. With gap set,
  // in_valid first drops for one cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
  endtask

  // Stream the words in prog under length len, then send the checksum
  // (optionally corrupted). Ends at the negedge that follows the CHK byte.
  task automatic run_load(input logic [15:0] len, input bit corrupt, input bit gap);
    logic [7:0] c;
    c = 8'h00;
    send_byte(len[15:8], gap); c ^= len[15:8];
    send_byte(len[7:0], gap);  c ^= len[7:0];
    for (int i = 0; i < prog.size(); i++) begin
      wr_t e;
      send_byte(prog[i][15:8], gap); c ^= prog[i][15:8];
      send_byte(prog[i][7:0], gap);  c ^= prog[i][7:0];
      e.addr = 10'(i);
      e.data = prog[i];
      e.cyc  = acc_cyc;
      sb.push_back(e);
    end
    run_chk = c;
    check("cpu_held_before_chk", 32'(cpu_reset_n), 32'd0);
    send_byte(corrupt ? (c ^ 8'h01) : c, gap);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic pulse_eop();
    @(negedge clk);
    eop = 1'b1;
    @(negedge clk);
    eop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_reset_n), 32'd0);
    check({tag, "_wcount"}, 32'(word_count), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  // Two-word load (0x9010, 0xC000) that runs to DONE and then restarts.
  task automatic good_two_word(input bit gap, input string tag);
    prog = '{16'h9010, 16'hC000};
    run_load(16'd2, 1'b0, gap);
    check({tag, "_chk_value"}, 32'(run_chk), 32'h42);
    check({tag, "_cpu_released"}, 32'(cpu_reset_n), 32'd1);
    check({tag, "_wcount"}, 32'(word_count), 32'd2);
    check({tag, "_ready_run"}, 32'(in_ready), 32'd0);
    check({tag, "_done_early"}, 32'(done), 32'd0);
    pulse_eop();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_still_released"}, 32'(cpu_reset_n), 32'd1);
    pulse_restart();
    check_idle({tag, "_restart"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0; eop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu", 32'(cpu_reset_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    reset = 1'b0;

    // Basic load, back-to-back bytes.
    good_two_word(1'b0, "t1");

    // Checksum mismatch; eop and stray bytes have no effect while in ERR.
    prog = '{16'h9010, 16'hC000};
    run_load(16'd2, 1'b1, 1'b0);
    check("badchk_error", 32'(error), 32'd1);
    check("badchk_cpu", 32'(cpu_reset_n), 32'd0);
    check("badchk_ready", 32'(in_ready), 32'd0);
    pulse_eop();
    check("badchk_eop_ignored", 32'(done), 32'd0);
    @(negedge clk); in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("badchk_stray", 32'(in_ready), 32'd0);
    check("badchk_error_hold", 32'(error), 32'd1);
    pulse_restart();
    check_idle("badchk_restart");

    // Length 0 and length 1025 are rejected right after LEN_LO.
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("len0_error", 32'(error), 32'd1);
    check("len0_ready", 32'(in_ready), 32'd0);
    pulse_restart();
    check_idle("len0_restart");
    send_byte(8'h04, 1'b0); send_byte(8'h01, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    check("len1025_error", 32'(error), 32'd1);
    check("len1025_wcount", 32'(word_count), 32'd0);
    pulse_restart();
    check_idle("len1025_restart");

    // Same program with in_valid toggling every cycle, then held high.
    good_two_word(1'b1, "gap");
    good_two_word(1'b0, "cont");

    // Full-size program: data[i] = i.
    prog.delete();
    for (int i = 0; i < 1024; i++) prog.push_back(16'(i));
    run_load(16'd1024, 1'b0, 1'b0);
    check("big_wcount", 32'(word_count), 32'd1024);
    check("big_addr_wrap", 32'(mem_addr), 32'd0);
    check("big_cpu", 32'(cpu_reset_n), 32'd1);
    check("big_last_data", 32'(mem_wdata), 32'h03FF);
    pulse_restart();
    check("big_restart_ignored_cpu", 32'(cpu_reset_n), 32'd1);
    check("big_restart_ignored_ready", 32'(in_ready), 32'd0);
    pulse_eop();
    check("big_done", 32'(done), 32'd1);
    pulse_restart();
    check_idle("big_restart");

    // Asynchronous reset while word 1 is in DATA_LO.
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h90, 1'b0); send_byte(8'h10, 1'b0);
    begin
      wr_t e;
      e.addr = 10'd0; e.data = 16'h9010; e.cyc = acc_cyc;
      sb.push_back(e);
    end
    send_byte(8'hC0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h00;
    #2 reset = 1'b1;
    #1;
    in_valid = 1'b0;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_cpu", 32'(cpu_reset_n), 32'd0);
    check("arst_wcount", 32'(word_count), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("arst_sb_empty", 32'(sb.size()), 32'd0);
    good_two_word(1'b0, "after_rst");

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
